fifo_flex: RTL
==============

Name: fifo_flex

Overview:
Parametrised synchronous single-clock FIFO. It is the next generation of the team's basic FIFO.
- Adds programmable almost-full/almost-empty thresholds, an occupancy level output, and overflow/underflow protection with sticky error flags.
- Adds a synchronous flush and a selectable read mode: first-word-fall-through (FWFT) or registered output.
- Sits between TPU datapath stages, e.g. weight/activation staging and result drain.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- LOG_DEPTH, 3, log2 of the depth; must be >= 1.
- FIFO_DEPTH, 2**LOG_DEPTH, number of entries; derived, do not override.
- AFULL_THRESH, FIFO_DEPTH-1, almost_full asserts when level >= this value.
- AEMPTY_THRESH, 1, almost_empty asserts when level <= this value.
- FWFT, 1, read mode: 1 = first-word-fall-through, 0 = registered output with 1-cycle read latency.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- wrreq  in  1  write request.
- data  in  DATA_WIDTH  write data.
- rdreq  in  1  read request.
- q  out  DATA_WIDTH  read data.
- rdvalid  out  1  q holds valid data.
- full  out  1  level == FIFO_DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- level  out  LOG_DEPTH+1  current occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  clears overflow and underflow.

Behaviour:
- Reset (rstn=0 at posedge):
  - Read pointer, write pointer and level are 0; overflow=0, underflow=0.
  - FWFT=0 only: q=0 and rdvalid=0.
  - Memory contents are not reset.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full = (AFULL_THRESH==0).
- Status outputs (full, empty, almost_*, level) are combinational from registered state only; there is no input-to-status path.
- Accepted write: wr_ok = wrreq & (~full | rd_ok). The word is written to mem[wptr] and wptr increments modulo FIFO_DEPTH (natural wrap).
- Accepted read: rd_ok = rdreq & ~empty. rptr increments with wrap.
- Read and write in the same cycle:
  - When full, both are accepted; level is unchanged.
  - When empty, only the write is accepted; the read is rejected and sets underflow.
- Level update: +1 on write only, -1 on read only, unchanged otherwise. It never exceeds FIFO_DEPTH and never goes below 0.
- Rejected write: wrreq & full & ~rd_ok sets overflow; memory and pointers are unchanged.
- Rejected read: rdreq & empty sets underflow; pointers are unchanged.
- err_clr: clears both sticky flags next cycle. If a new error occurs in the same cycle, the set wins.
- flush (rstn=1):
  - Next cycle: rptr=wptr=level=0, and in FWFT=0 rdvalid=0.
  - flush has priority over wrreq/rdreq in the same cycle: both are dropped, with no error flags and no visible memory effect.
  - Sticky flags are preserved across flush.
- FWFT=1: q = mem[rptr] combinationally; rdvalid = ~empty. rdreq acknowledges (pops) the word currently on q.
- FWFT=0:
  - On rd_ok, q <= mem[rptr] and rdvalid <= 1 at the next edge. Otherwise rdvalid <= 0 and q holds its last value.
  - Read latency is 1 cycle.
- Written-word visibility: a word written at cycle N is readable at N+1 in both modes, i.e. empty deasserts at N+1. There is no same-cycle write-to-read bypass.

Decomposition:
- Package fifo_pkg holds:
  - fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, overflow, underflow}.
  - Localparam helper functions for level width.
- Sub-module fifo_mem: simple dual-port register array with a synchronous write port and an asynchronous read port, parametrised by DATA_WIDTH and LOG_DEPTH.
- fifo_flex holds the pointer/level register struct, the error flags and the read-mode output logic.

Test Plan (DATA_WIDTH=32, LOG_DEPTH=3, defaults unless stated):
- Fill and drain: write 0x10..0x17 over 8 cycles, then read 8 with FWFT=1.
  - While filling: level steps 1..8; almost_full at level 7; full at 8.
  - While draining: q shows 0x10..0x17 in order; empty after the last read; overflow=0 and underflow=0.
- Overflow: fill to 8 entries, then wrreq with data 0xDEAD.
  - overflow=1 next cycle; level stays 8; subsequent drain never yields 0xDEAD.
  - err_clr for one cycle clears overflow.
- Full with read+write: at level 8, hold wrreq and rdreq together for 4 cycles writing 0xA0..0xA3.
  - level stays 8; no overflow; after a full drain the order is the original words 5..8 followed by 0xA0..0xA3.
- Empty read: rdreq on an empty FIFO, then wrreq and rdreq together on an empty FIFO with data 0x55.
  - underflow=1; level=1 after the second cycle; q=0x55 while rdvalid=1.
- FWFT=0 latency: write 0x01 and 0x02, then issue two back-to-back rdreq.
  - rdvalid is high on the cycle after each rdreq, with q=0x01 then 0x02; rdvalid is low otherwise.
- Flush and reset:
  - With level 5 and flush, wrreq and rdreq all asserted together: next cycle level=0, empty=1, sticky flags unchanged.
  - With rstn=0 mid-fill: all outputs reach their reset values at the next edge.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
// fifo_pkg: shared types and helpers for the fifo_flex FIFO.
//   fifo_status_t : packed bundle of the FIFO status/error flags.
//   level_width() : number of bits needed to hold an occupancy of 0..2**log_depth.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Occupancy spans 0..2**log_depth inclusive, so it needs one extra bit.
  function automatic int level_width(input int log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// fifo_mem: simple dual-port register array.
//   clk      : clock, write on posedge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (asynchronous read)
//   rdata_o  : read data, combinational from raddr_i
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [LOG_DEPTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [LOG_DEPTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**LOG_DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy level, sticky overflow/underflow flags, synchronous
// flush and selectable read mode (FWFT or 1-cycle registered output).
//   clk, rstn          : clock and synchronous active-low reset
//   flush              : clear contents (pointers/level) next cycle
//   wrreq, data        : write request and data
//   rdreq              : read request (pops the head word)
//   q, rdvalid         : read data and its valid flag
//   full, empty, almost_full, almost_empty, level : status from registered state
//   overflow, underflow: sticky error flags, cleared by err_clr
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int LOG_DEPTH     = 3,
  parameter int FIFO_DEPTH    = 2**LOG_DEPTH,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter bit FWFT          = 1'b1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                flush,
  input  logic                                wrreq,
  input  logic [DATA_WIDTH-1:0]               data,
  input  logic                                rdreq,
  output logic [DATA_WIDTH-1:0]               q,
  output logic                                rdvalid,
  output logic                                full,
  output logic                                empty,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [level_width(LOG_DEPTH)-1:0]   level,
  output logic                                overflow,
  output logic                                underflow,
  input  logic                                err_clr
);

  localparam int LVL_W = level_width(LOG_DEPTH);
  localparam int PTR_W = LOG_DEPTH;

  typedef struct packed {
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [LVL_W-1:0] level;
  } ptr_state_t;

  ptr_state_t            ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  fifo_status_t          status_s;
  logic                  rd_acc_s, wr_acc_s, rd_ok_s, wr_ok_s;
  logic                  ovf_set_s, udf_set_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // Status flags are derived purely from registered state.
  always_comb begin
    status_s              = '0;
    status_s.full         = (ptr_q.level == LVL_W'(FIFO_DEPTH));
    status_s.empty        = (ptr_q.level == LVL_W'(0));
    status_s.almost_full  = (ptr_q.level >= LVL_W'(AFULL_THRESH));
    status_s.almost_empty = (ptr_q.level <= LVL_W'(AEMPTY_THRESH));
    status_s.overflow     = ovf_q;
    status_s.underflow    = udf_q;
  end

  // Acceptance: a read frees a slot so a write at full still goes through;
  // flush drops both requests and suppresses any error they would raise.
  always_comb begin
    rd_acc_s  = rdreq & ~status_s.empty;
    wr_acc_s  = wrreq & (~status_s.full | rd_acc_s);
    rd_ok_s   = rd_acc_s & ~flush;
    wr_ok_s   = wr_acc_s & ~flush;
    ovf_set_s = wrreq & status_s.full & ~rd_acc_s & ~flush;
    udf_set_s = rdreq & status_s.empty & ~flush;
  end

  // Pointer and level next-state.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else begin
      if (wr_ok_s) begin
        ptr_d.wptr = ptr_q.wptr + PTR_W'(1);
      end else begin
        ptr_d.wptr = ptr_q.wptr;
      end
      if (rd_ok_s) begin
        ptr_d.rptr = ptr_q.rptr + PTR_W'(1);
      end else begin
        ptr_d.rptr = ptr_q.rptr;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   ptr_d.level = ptr_q.level + LVL_W'(1);
        2'b01:   ptr_d.level = ptr_q.level - LVL_W'(1);
        default: ptr_d.level = ptr_q.level;
      endcase
    end
  end

  // Sticky error flags: a new error in the clearing cycle wins over err_clr.
  always_comb begin
    ovf_d = (ovf_q & ~err_clr) | ovf_set_s;
    udf_d = (udf_q & ~err_clr) | udf_set_s;
  end

  // Pointer/level and error flag registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG_DEPTH  (LOG_DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok_s),
    .waddr_i (ptr_q.wptr),
    .wdata_i (data),
    .raddr_i (ptr_q.rptr),
    .rdata_o (rdata_s)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented directly; rdreq acknowledges it.
      always_comb begin
        q       = rdata_s;
        rdvalid = ~status_s.empty;
      end
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] q_q, q_d;
      logic                  rdvalid_q, rdvalid_d;

      // q captures the head word on an accepted read, otherwise holds.
      always_comb begin
        if (rd_ok_s) begin
          q_d = rdata_s;
        end else begin
          q_d = q_q;
        end
        rdvalid_d = rd_ok_s;
      end

      // Registered read-data stage.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          q_q       <= '0;
          rdvalid_q <= 1'b0;
        end else begin
          q_q       <= q_d;
          rdvalid_q <= rdvalid_d;
        end
      end

      assign q       = q_q;
      assign rdvalid = rdvalid_q;
    end
  endgenerate

  assign full         = status_s.full;
  assign empty        = status_s.empty;
  assign almost_full  = status_s.almost_full;
  assign almost_empty = status_s.almost_empty;
  assign overflow     = status_s.overflow;
  assign underflow    = status_s.underflow;
  assign level        = ptr_q.level;

endmodule
